// File: rtl/video_pattern_generator.sv
// rtl/video_pattern_generator.sv - multi-mode video test-pattern beat source
module video_pattern_generator #(
  parameter int PIXELS_PER_BEAT = 4,
  parameter int PIXEL_WIDTH     = 64,
  parameter int CHECKER_SHIFT   = 5,
  parameter int BAR_SHIFT       = 7,
  parameter int BOX_SIZE        = 200,
  parameter int BORDER          = 20,
  parameter int STEP            = 8
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [15:0]                            video_width,
  input  logic [15:0]                            video_height,
  input  logic [1:0]                             mode,
  input  logic [23:0]                            solid_color,
  input  logic                                   start_frame,
  output logic                                   busy,
  input  logic                                   ready,
  output logic                                   valid,
  output logic [PIXELS_PER_BEAT*PIXEL_WIDTH-1:0] bits,
  output logic                                   sof,
  output logic                                   eol,
  output logic [15:0]                            frame_count
);
  localparam int P  = PIXELS_PER_BEAT;
  localparam int BW = P * PIXEL_WIDTH;
  localparam logic [16:0] P17      = 17'(P);
  localparam logic [16:0] BOX17    = 17'(BOX_SIZE);
  localparam logic [17:0] UP_SPAN  = 18'(STEP + BORDER + BOX_SIZE);
  localparam logic [17:0] DN_MIN   = 18'(STEP + BORDER);
  localparam logic [15:0] STEP16   = 16'(STEP);
  localparam logic [15:0] BORDER16 = 16'(BORDER);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t        state_q, state_d;
  logic [15:0]   cx_q, cx_d, cy_q, cy_d;
  logic [15:0]   width_q, width_d, height_q, height_d;
  logic [1:0]    mode_q, mode_d;
  logic [23:0]   color_q, color_d;
  logic [15:0]   bx_q, bx_d, by_q, by_d;
  logic          dir_x_q, dir_x_d, dir_y_q, dir_y_d;  // 1 = moving towards zero
  logic [15:0]   frame_count_q, frame_count_d;
  logic          valid_q, valid_d, sof_q, sof_d, eol_q, eol_d;
  logic [BW-1:0] bits_q, bits_d;

  logic          advance, line_end, last_line;
  logic [BW-1:0] beat_bits;
  logic [16:0]   px, py, w17, h17, bx17, by17;
  logic [23:0]   rgb, checker_rgb;
  logic          in_box;

  // Colour bar palette, left to right.
  function automatic logic [23:0] bar_rgb(input logic [2:0] bar);
    case (bar)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  endfunction

  // One bounce step on one axis, returns {negative_direction, new_position}.
  // Bounds are rearranged so every term stays non-negative in 18 bits.
  function automatic logic [16:0] box_step(input logic [15:0] pos, input logic neg,
                                           input logic [15:0] extent);
    logic [17:0] pos18, ext18;
    pos18 = {2'b00, pos};
    ext18 = {2'b00, extent};
    if (!neg) begin
      if (pos18 + UP_SPAN < ext18) box_step = {1'b0, pos + STEP16};
      else                         box_step = {1'b1, pos - STEP16};
    end else begin
      if (pos18 >= DN_MIN) box_step = {1'b1, pos - STEP16};
      else                 box_step = {1'b0, pos + STEP16};
    end
  endfunction

  // Pixel colours for the beat at (cx_q .. cx_q+P-1, cy_q) from the latched frame settings.
  always_comb begin
    beat_bits   = '0;
    px          = '0;
    rgb         = '0;
    checker_rgb = '0;
    in_box      = 1'b0;
    py          = {1'b0, cy_q};
    w17         = {1'b0, width_q};
    h17         = {1'b0, height_q};
    bx17        = {1'b0, bx_q};
    by17        = {1'b0, by_q};
    for (int i = 0; i < P; i++) begin
      px          = {1'b0, cx_q} + 17'(i);
      checker_rgb = (px[CHECKER_SHIFT] ^ py[CHECKER_SHIFT]) ? 24'hFFFFFF : 24'hCCCCCC;
      in_box      = (px >= bx17) && (px < bx17 + BOX17) && (py >= by17) && (py < by17 + BOX17);
      case (mode_q)
        2'd0:    rgb = bar_rgb(px[BAR_SHIFT+2:BAR_SHIFT]);
        2'd1:    rgb = checker_rgb;
        2'd2:    rgb = in_box ? 24'hFFCC66 : checker_rgb;
        default: rgb = color_q;
      endcase
      if (px == 17'd0 || py == 17'd0 || px == w17 - 17'd1 || py == h17 - 17'd1) rgb = 24'h0000FF;
      if (px >= w17) rgb = 24'h000000;
      beat_bits[i*PIXEL_WIDTH +: PIXEL_WIDTH] = PIXEL_WIDTH'(rgb);
    end
  end

  // Frame sequencing: issue beats on advance, walk the raster, bounce the box at frame end.
  always_comb begin
    state_d       = state_q;
    cx_d          = cx_q;
    cy_d          = cy_q;
    width_d       = width_q;
    height_d      = height_q;
    mode_d        = mode_q;
    color_d       = color_q;
    bx_d          = bx_q;
    by_d          = by_q;
    dir_x_d       = dir_x_q;
    dir_y_d       = dir_y_q;
    frame_count_d = frame_count_q;
    valid_d       = valid_q;
    sof_d         = sof_q;
    eol_d         = eol_q;
    bits_d        = bits_q;

    advance   = ready | ~valid_q;
    line_end  = ({1'b0, cx_q} + P17) >= {1'b0, width_q};
    last_line = ({1'b0, cy_q} + 17'd1) >= {1'b0, height_q};

    if (advance) begin
      if (state_q == ACTIVE) begin
        bits_d  = beat_bits;
        sof_d   = (cx_q == 16'd0) && (cy_q == 16'd0);
        eol_d   = line_end;
        valid_d = 1'b1;
        if (!line_end) begin
          cx_d = cx_q + 16'(P);
        end else begin
          cx_d = 16'd0;
          if (!last_line) begin
            cy_d = cy_q + 16'd1;
          end else begin
            state_d            = IDLE;
            frame_count_d      = frame_count_q + 16'd1;
            {dir_x_d, bx_d}    = box_step(bx_q, dir_x_q, width_q);
            {dir_y_d, by_d}    = box_step(by_q, dir_y_q, height_q);
          end
        end
      end else begin
        valid_d = 1'b0;
      end
    end

    if (state_q == IDLE && start_frame) begin
      state_d  = ACTIVE;
      cx_d     = 16'd0;
      cy_d     = 16'd0;
      width_d  = video_width;
      height_d = video_height;
      mode_d   = mode;
      color_d  = solid_color;
    end
  end

  // State, frame latches, box position and the registered output stage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cx_q          <= '0;
      cy_q          <= '0;
      width_q       <= '0;
      height_q      <= '0;
      mode_q        <= '0;
      color_q       <= '0;
      bx_q          <= BORDER16;
      by_q          <= BORDER16;
      dir_x_q       <= 1'b0;
      dir_y_q       <= 1'b0;
      frame_count_q <= '0;
      valid_q       <= 1'b0;
      sof_q         <= 1'b0;
      eol_q         <= 1'b0;
      bits_q        <= '0;
    end else begin
      state_q       <= state_d;
      cx_q          <= cx_d;
      cy_q          <= cy_d;
      width_q       <= width_d;
      height_q      <= height_d;
      mode_q        <= mode_d;
      color_q       <= color_d;
      bx_q          <= bx_d;
      by_q          <= by_d;
      dir_x_q       <= dir_x_d;
      dir_y_q       <= dir_y_d;
      frame_count_q <= frame_count_d;
      valid_q       <= valid_d;
      sof_q         <= sof_d;
      eol_q         <= eol_d;
      bits_q        <= bits_d;
    end
  end

  assign busy        = (state_q == ACTIVE) | valid_q;
  assign valid       = valid_q;
  assign bits        = bits_q;
  assign sof         = sof_q;
  assign eol         = eol_q;
  assign frame_count = frame_count_q;
endmodule
